// File: rtl/acc_cpu_pkg.sv
// Shared types and instruction-field positions for the accumulator CPU sequencer.
package acc_cpu_pkg;

  // Sequencer control states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Opcodes live in instr[7:4]; 4'hA..4'hE are unassigned and behave as NOP
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDR = 4'h1,
    OP_STR = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_LDI = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_HLT = 4'hF
  } opcode_t;

  // Instruction field positions
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int RA_MSB  = 1;
  localparam int RA_LSB  = 0;

  // Extract the opcode field of an instruction byte
  function automatic opcode_t decode_op(input logic [7:0] instr);
    return opcode_t'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU: register-operand operations only.
// The immediate load (LDI) is handled by the sequencer since it needs instr bits.
module acc_cpu_alu
  import acc_cpu_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] register_value,
  input  logic [3:0] opcode,
  output logic [7:0] result,
  output logic       load_acc
);

  // Compute the new accumulator value; arithmetic wraps mod 256
  always_comb begin
    result   = acc;
    load_acc = 1'b0;
    case (opcode_t'(opcode))
      OP_LDR: begin result = register_value;       load_acc = 1'b1; end
      OP_ADD: begin result = acc + register_value; load_acc = 1'b1; end
      OP_SUB: begin result = acc - register_value; load_acc = 1'b1; end
      OP_AND: begin result = acc & register_value; load_acc = 1'b1; end
      OP_OR:  begin result = acc | register_value; load_acc = 1'b1; end
      default: begin
        result   = acc;
        load_acc = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_cpu_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator datapath.
// IDLE -> FETCH (wait for ack) -> DECODE -> EXECUTE -> FETCH / HALT.
// Optional: define ACC_SEQ_PERF_EN to add the saturating retired_cnt output.
module acc_cpu_sequencer
  import acc_cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [1:0]      register_address,
  output logic            we,
  output logic [7:0]      accumulator_output,
  input  logic [7:0]      register_value,
  output logic            halted,
  output logic [PC_W-1:0] pc_dbg
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [15:0]     retired_cnt
`endif
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      acc_reg, acc_next;
  logic [7:0]      instr_reg, instr_next;
  opcode_t         op_cur;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;
  logic [7:0]      alu_result;
  logic            alu_load;

  assign op_cur      = decode_op(instr_reg);
  assign pc_inc      = pc_reg + PC_W'(1);
  assign jump_target = PC_W'(instr_reg[IMM_MSB:IMM_LSB]);

  acc_cpu_alu u_alu (
    .acc            (acc_reg),
    .register_value (register_value),
    .opcode         (instr_reg[OPC_MSB:OPC_LSB]),
    .result         (alu_result),
    .load_acc       (alu_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; FETCH stalls until the memory acknowledges
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = imem_ack ? DECODE : FETCH;
      DECODE:  state_next = EXECUTE;
      EXECUTE: state_next = (op_cur == OP_HLT) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; rst masks we so an aborted STR never writes on the reset edge
  always_comb begin
    imem_req         = (state_reg == FETCH);
    halted           = (state_reg == HALT);
    register_address = 2'd0;
    if (state_reg == DECODE || state_reg == EXECUTE) begin
      register_address = instr_reg[RA_MSB:RA_LSB];
    end
    we = (state_reg == EXECUTE) && (op_cur == OP_STR) && !rst;
  end

  assign imem_addr          = pc_reg;
  assign pc_dbg             = pc_reg;
  assign accumulator_output = acc_reg;

  // Datapath next values: instruction latch, accumulator update, pc sequencing
  always_comb begin
    pc_next    = pc_reg;
    acc_next   = acc_reg;
    instr_next = instr_reg;
    if (state_reg == FETCH && imem_ack) begin
      instr_next = imem_data;
    end
    if (state_reg == EXECUTE) begin
      case (op_cur)
        OP_JMP:  pc_next = jump_target;
        OP_JZ:   pc_next = (acc_reg == 8'd0) ? jump_target : pc_inc;
        OP_HLT:  pc_next = pc_reg;
        default: pc_next = pc_inc;
      endcase
      if (alu_load) begin
        acc_next = alu_result;
      end else if (op_cur == OP_LDI) begin
        acc_next = {4'b0000, instr_reg[IMM_MSB:IMM_LSB]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= '0;
      acc_reg   <= 8'd0;
      instr_reg <= 8'd0;
    end else begin
      pc_reg    <= pc_next;
      acc_reg   <= acc_next;
      instr_reg <= instr_next;
    end
  end

`ifdef ACC_SEQ_PERF_EN
  logic [15:0] retired_reg;

  // Count every instruction leaving EXECUTE (HLT included), saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= 16'd0;
    end else if (state_reg == EXECUTE && retired_reg != 16'hFFFF) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign retired_cnt = retired_reg;
`endif

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Self-checking bench for acc_cpu_sequencer: directed programs plus random
// programs, checked against an instruction-level reference model.
module tb_acc_cpu_sequencer;

  localparam int PC_W  = 4;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [7:0]      imem_data = 8'd0;
  logic [1:0]      register_address;
  logic            we;
  logic [7:0]      accumulator_output;
  logic [7:0]      register_value;
  logic            halted;
  logic [PC_W-1:0] pc_dbg;
`ifdef ACC_SEQ_PERF_EN
  logic [15:0]     retired_cnt;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  int         first_we_cyc;
  logic [7:0] imem    [DEPTH];
  logic [7:0] m_regs  [4];
  logic [7:0] rf      [4];
  logic [7:0] rf_init [4];
  logic       rf_load = 1'b0;

  always #5 clk = ~clk;

  // Register file environment: combinational read, write on rising edge
  assign register_value = rf[register_address];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
    end else if (we) begin
      rf[register_address] <= accumulator_output;
    end
  end

  acc_cpu_sequencer #(.PC_W(PC_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_data          (imem_data),
    .register_address   (register_address),
    .we                 (we),
    .accumulator_output (accumulator_output),
    .register_value     (register_value),
    .halted             (halted),
    .pc_dbg             (pc_dbg)
`ifdef ACC_SEQ_PERF_EN
    ,
    .retired_cnt        (retired_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < DEPTH; i++) imem[i] = 8'h00;
  endtask

  // Reset, preload the register file from the model, check the reset state
  task automatic do_reset();
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    rf_init   = m_regs;
    rf_load   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_load = 1'b0;
    check("rst_req",    32'(imem_req), 32'(0));
    check("rst_we",     32'(we), 32'(0));
    check("rst_ra",     32'(register_address), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_acc",    32'(accumulator_output), 32'(0));
    check("rst_pc",     32'(pc_dbg), 32'(0));
`ifdef ACC_SEQ_PERF_EN
    check("rst_retired", 32'(retired_cnt), 32'(0));
`endif
    rst = 1'b0;
  endtask

  // Run the program in imem from pc=0, one model step per acknowledged fetch.
  // wait_fixed < 0 picks a random 0..3 wait per fetch.
  task automatic run_program(input int max_instr, input int wait_fixed);
    int         cyc       = 0;
    int         m_pc      = 0;
    int         m_acc     = 0;
    bit         m_halt    = 1'b0;
    int         retired   = 0;
    int         wait_left = -1;
    int         ack_cyc   = -100;
    int         we_due    = -1;
    int         exp_waddr = 0;
    int         exp_wdata = 0;
    bit         done      = 1'b0;
    bit         exp_we;
    logic [7:0] ins;
    logic [7:0] ack_ins   = 8'h00;
    int         op, ra, imm, npc, rv;
    first_we_cyc = -1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 1000) break;
      exp_we = (cyc == we_due);
      if (we || exp_we) begin
        check("we", 32'(we), 32'(exp_we));
        if (exp_we) begin
          check("we_addr", 32'(register_address), 32'(exp_waddr));
          check("we_data", 32'(accumulator_output), 32'(exp_wdata));
        end
        if (we && first_we_cyc < 0) first_we_cyc = cyc;
      end
      if (cyc == ack_cyc + 1) check("dec_ra", 32'(register_address), 32'(ack_ins[1:0]));
      if (imem_req) begin
        if (m_halt) check("req_after_halt", 32'(imem_req), 32'(0));
        if (wait_left < 0) begin
          if (ack_cyc >= 0) check("latency", 32'(cyc - ack_cyc), 32'(3));
          check("pc",       32'(pc_dbg), 32'(m_pc));
          check("addr",     32'(imem_addr), 32'(m_pc));
          check("acc",      32'(accumulator_output), 32'(m_acc));
          check("ra_fetch", 32'(register_address), 32'(0));
          check("halted",   32'(halted), 32'(0));
`ifdef ACC_SEQ_PERF_EN
          check("retired",  32'(retired_cnt), 32'(retired));
`endif
          if (retired >= max_instr) done = 1'b1;
          else wait_left = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
        end else begin
          check("addr_hold", 32'(imem_addr), 32'(m_pc));
        end
        if (done) begin
          imem_ack = 1'b0;
        end else if (wait_left == 0) begin
          // Acknowledge and step the instruction-level model
          ins       = imem[m_pc];
          ack_ins   = ins;
          imem_ack  = 1'b1;
          imem_data = ins;
          ack_cyc   = cyc;
          wait_left = -1;
          retired++;
          op  = int'(ins[7:4]);
          ra  = int'(ins[1:0]);
          imm = int'(ins[3:0]);
          rv  = int'(m_regs[ra]);
          npc = (m_pc + 1) % DEPTH;
          case (op)
            1:  m_acc = rv;
            2:  begin
                  m_regs[ra] = 8'(m_acc);
                  we_due     = cyc + 2;
                  exp_waddr  = ra;
                  exp_wdata  = m_acc;
                end
            3:  m_acc = (m_acc + rv) % 256;
            4:  m_acc = (m_acc - rv + 256) % 256;
            5:  m_acc = m_acc & rv;
            6:  m_acc = m_acc | rv;
            7:  m_acc = imm;
            8:  npc = imm;
            9:  if (m_acc == 0) npc = imm;
            15: begin m_halt = 1'b1; npc = m_pc; end
            default: ;
          endcase
          m_pc = npc;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 8'($urandom);
          wait_left--;
        end
      end else begin
        // Outside FETCH the ack and data lines carry noise that must be ignored
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 8'($urandom);
        if (halted || (m_halt && cyc == ack_cyc + 3))
          check("halted", 32'(halted), 32'(m_halt && cyc >= ack_cyc + 3));
        if (m_halt && cyc == ack_cyc + 3) begin
          check("halt_pc",  32'(pc_dbg), 32'(m_pc));
          check("halt_acc", 32'(accumulator_output), 32'(m_acc));
`ifdef ACC_SEQ_PERF_EN
          check("halt_retired", 32'(retired_cnt), 32'(retired));
`endif
        end
        if (m_halt && cyc >= ack_cyc + 8) done = 1'b1;
      end
    end
    check("run_done", 32'(done), 32'(1));
    imem_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("regfile", 32'(rf[i]), 32'(m_regs[i]));
  endtask

  initial begin
    // LDI 5, STR r2, HLT with zero-wait ack
    clear_imem();
    imem[0] = 8'h75; imem[1] = 8'h22; imem[2] = 8'hF0;
    m_regs = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    run_program(10, 0);
    check("we_first_cyc", 32'(first_we_cyc), 32'(6));

    // Same program, every fetch stalled 3 cycles
    do_reset();
    run_program(10, 3);

    // Wrapping ADD and SUB
    clear_imem();
    imem[0] = 8'h7F; imem[1] = 8'h33; imem[2] = 8'h70; imem[3] = 8'h41; imem[4] = 8'hF0;
    m_regs = '{8'h00, 8'h01, 8'h00, 8'hF5};
    do_reset();
    run_program(10, -1);

    // JZ taken / not taken, JMP, and pc wrap from 15 to 0
    clear_imem();
    imem[0]  = 8'h70; imem[1]  = 8'h99; imem[9] = 8'h73; imem[10] = 8'h9A;
    imem[11] = 8'h8F; imem[15] = 8'h71;
    do_reset();
    run_program(8, 0);

    // Reset during EXECUTE of STR aborts the write
    clear_imem();
    imem[0] = 8'h75; imem[1] = 8'h22;
    m_regs = '{8'h00, 8'h00, 8'hAA, 8'h00};
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      imem_ack  = imem_req;
      imem_data = imem[imem_addr];
    end
    check("abort_pre_we", 32'(we), 32'(1));
    rst = 1'b1;
    #1;
    check("abort_we", 32'(we), 32'(0));
    @(negedge clk);
    check("abort_pc",  32'(pc_dbg), 32'(0));
    check("abort_acc", 32'(accumulator_output), 32'(0));
    check("abort_rf2", 32'(rf[2]), 32'(8'hAA));
`ifdef ACC_SEQ_PERF_EN
    check("abort_retired", 32'(retired_cnt), 32'(0));
`endif

    // Random programs with random stalls
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) imem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) m_regs[i] = 8'($urandom);
      do_reset();
      run_program(30, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
